hien_thi_8bit: RTL
==================

# hien_thi_8bit

Display back-end for the 8-bit up/down counter. It takes the counter's 8-bit binary output and converts it sequentially to three BCD digits (000–255). It then drives a time-multiplexed, 3-digit, common-anode 7-segment display with leading-zero blanking. It sits directly downstream of the counter `out` bus, on the same clock.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; legal range ≥ 2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising edge of `clk`.
- `value`  in  8  unsigned binary count to display; sampled only in CAPTURE.
- `bcd`  out  12  last committed conversion, {hundreds, tens, units}, 4 bits each.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low; a 0 lights the segment.
- `an`  out  3  digit enables {hundreds, tens, units}, active-low, one-hot-low.

## Operation
- Reset (`reset`=0 at an edge): `bcd`=12'h000, `seg`=7'h7F, `an`=3'b111. Converter goes to CAPTURE, shift count to 0, scan prescaler to 0, digit index to 0 (units).
- Converter FSM, free-running, 10-cycle period:
  - CAPTURE (1 cycle): latch `value` into a 20-bit shift register {12'h000, value}, count=0, go to SHIFT.
  - SHIFT (8 cycles): double-dabble. Each BCD nibble ≥ 5 gets +3, then the whole register shifts left 1. Count increments; after the 8th shift go to COMMIT.
  - COMMIT (1 cycle): copy register[19:8] to the `bcd` register, go to CAPTURE.
- Arithmetic: nibble add-3 happens before the shift in the same cycle. No nibble exceeds 9 after COMMIT. Input 255 gives 12'h255.
- A change on `value` during SHIFT/COMMIT is ignored until the next CAPTURE. No partial result ever reaches `bcd`.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→2→0. Index 0 = units, 1 = tens, 2 = hundreds.
  - Index 3 is unreachable; if entered, it forces 0 on the next edge.
- Output register, updated every cycle from the current index and `bcd`:
  - `an` drives low only the bit of the current digit.
  - `seg` = font of the selected nibble.
- Font (active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex). Nibbles A–F are never produced; if seen, they map to 7F.
- Leading-zero blanking:
  - Hundreds digit: `seg`=7F if hundreds==0.
  - Tens digit: `seg`=7F if hundreds==0 and tens==0.
  - Units digit: never blanked.
  - `an` still cycles for blanked digits.

## Timing
- `value` to `bcd`: `bcd` updates on the COMMIT edge, 9 cycles after the CAPTURE edge. Worst case from a `value` change to a `bcd` update is 19 cycles.
- `bcd`/index to `seg`/`an`: 1 cycle (registered outputs).
- Each digit is active for exactly SCAN_DIV cycles; full refresh is 3×SCAN_DIV cycles.
- `an` and `seg` change on the same edge; no glitch cycle with a wrong segment pattern on an enabled digit.
- Reset mid-conversion or mid-scan: the edge with `reset`=0 sets all reset values. The first CAPTURE is on the first edge with `reset`=1. The first non-reset `bcd` arrives 9 cycles later.

## Structure
- Shared package, `hien_thi_pkg`:
  - FSM state encoding: CAPTURE, SHIFT, COMMIT.
  - The 10 font constants and SEG_BLANK=7'h7F.
  - NUM_DIGITS=3.
- Sub-module `bin2bcd_seq`: contains the CAPTURE/SHIFT/COMMIT FSM and the shift register. Ports: `clk`, `reset`, `value`, `bcd`.
- Top level holds the prescaler, digit index, font/blanking mux and the output registers.

## Test plan
Bench uses SCAN_DIV=4 and a 20 ns clock.
- Reset held low 5 cycles with `value`=8'd200 → `seg`=7F, `an`=111, `bcd`=000 throughout. After release, `bcd`=200 within 10 cycles.
- `value`=0 → `bcd`=000. Units shows 40 with `an`=110. Tens and hundreds show 7F with `an`=101/011. Each `an` state lasts 4 cycles.
- `value`=255 → `bcd`=255. `seg`=12 at `an`=110, 12 at `an`=101, 24 at `an`=011.
- `value`=105 → `bcd`=105. The tens digit shows 40, not blanked, because hundreds=1.
- `value`=9, then `value` switched to 10 in the 3rd SHIFT cycle:
  - The next COMMIT gives `bcd`=009.
  - The following COMMIT gives `bcd`=010, with units 40, tens 79, hundreds 7F.
- `reset` pulsed low for 1 cycle mid-SHIFT while `an`=101 → next edge gives `an`=111, `seg`=7F, `bcd`=000. Scanning restarts at units.

Source files
------------

// File: rtl/hien_thi_pkg.sv
// Shared types and constants for the 3-digit display back-end.
// Holds converter states, font table and the double-dabble step.
package hien_thi_pkg;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    SHIFT   = 2'd1,
    COMMIT  = 2'd2
  } conv_state_t;

  localparam int NUM_DIGITS = 3;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] font(
    input logic [3:0] n
  );
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Add-3 on every BCD nibble >= 5, then shift left by one.
  function automatic logic [19:0] dabble(
    input logic [19:0] r
  );
    logic [19:0] a;
    a = r;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[8+4*i +: 4] >= 4'd5)
        a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter, 10-cycle period.
// Ports: clk, reset (sync, active-low), value[7:0] in, bcd[11:0] out.
module bin2bcd_seq
  import hien_thi_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [11:0] bcd
);

  conv_state_t state;
  logic [19:0] sr;
  logic [2:0]  cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CAPTURE;
      sr    <= '0;
      cnt   <= '0;
      bcd   <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          sr    <= {12'h000, value};
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          sr  <= dabble(sr);
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7)
            state <= COMMIT;
        end
        COMMIT: begin
          // Only a finished conversion ever reaches bcd.
          bcd   <= sr[19:8];
          state <= CAPTURE;
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: rtl/hien_thi_8bit.sv
// Multiplexed 3-digit common-anode 7-seg driver with zero blanking.
// Ports: clk, reset (sync, active-low), value[7:0], bcd, seg, an.
module hien_thi_8bit
  import hien_thi_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [1:0] LAST = 2'(NUM_DIGITS - 1);

  logic [PW-1:0] psc;
  logic [1:0]    idx;
  logic [6:0]    seg_next;
  logic [2:0]    an_next;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .bcd   (bcd)
  );

  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = 3'b111;
    case (idx)
      2'd0: begin
        an_next  = 3'b110;
        seg_next = font(bcd[3:0]);
      end
      2'd1: begin
        an_next = 3'b101;
        if (bcd[11:4] != 8'h00)
          seg_next = font(bcd[7:4]);
      end
      2'd2: begin
        an_next = 3'b011;
        if (bcd[11:8] != 4'h0)
          seg_next = font(bcd[11:8]);
      end
      default: begin
        seg_next = SEG_BLANK;
        an_next  = 3'b111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      psc <= '0;
      idx <= '0;
      seg <= SEG_BLANK;
      an  <= 3'b111;
    end else begin
      seg <= seg_next;
      an  <= an_next;
      if (psc == PMAX) begin
        psc <= '0;
        idx <= (idx >= LAST) ? 2'd0 : idx + 2'd1;
      end else begin
        psc <= psc + 1'b1;
        if (idx == 2'd3)
          idx <= 2'd0;
      end
    end
  end

endmodule
